// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the cache miss/fill interface.
// Accepts one request at a time (word write or line-fill read), waits LATENCY
// cycles, then returns either a single write-ack beat or a critical-word-first
// burst of LINE_WORDS beats that wraps within the line.
// Optional feature: define MEM_TRACE_EN to display every committed write as
// "[0x<byte addr>]=0x<data>" in simulation.
module mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_last,
    output logic [31:0] resp_rdata,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LINE_MASK = DEPTH_LOG2'(LINE_WORDS - 1);
    localparam logic [4:0] LAST_BEAT = 5'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WACK  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [4:0]              beat_q, beat_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_last_q, resp_last_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;

    // Latched request payload
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;

    // Backing store; not cleared by reset
    logic [31:0]             ram [0:DEPTH-1];
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_widx;
    logic [31:0]             ram_wdata;

    // Response start: either straight from IDLE (zero latency) or end of WAIT
    logic                    start;
    logic                    op_we;
    logic [DEPTH_LOG2-1:0]   op_idx;
    logic [31:0]             op_wdata;

    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    unused_addr;

    assign req_idx     = req_addr[DEPTH_LOG2+1:2];
    // Byte-offset bits and bits above the store are deliberately ignored (aliasing)
    assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

    // Word index of beat k of a line, wrapping inside the line of idx
    function automatic logic [DEPTH_LOG2-1:0] wrap_idx(input logic [DEPTH_LOG2-1:0] idx,
                                                       input logic [4:0]            k);
        return (idx & ~LINE_MASK) | ((idx + DEPTH_LOG2'(k)) & LINE_MASK);
    endfunction

    // Next-state, next-output and store-write decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_last_d  = 1'b0;
        resp_rdata_d = resp_rdata_q;
        ram_we       = 1'b0;
        ram_widx     = idx_q;
        ram_wdata    = wdata_q;
        start        = 1'b0;
        op_we        = we_q;
        op_idx       = idx_q;
        op_wdata     = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        start    = 1'b1;
                        op_we    = req_we;
                        op_idx   = req_idx;
                        op_wdata = req_wdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    beat_d       = beat_q + 5'd1;
                    resp_valid_d = 1'b1;
                    resp_last_d  = ((beat_q + 5'd1) == LAST_BEAT);
                    resp_rdata_d = ram[wrap_idx(idx_q, beat_q + 5'd1)];
                end
            end
            WACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            resp_valid_d = 1'b1;
            if (op_we) begin
                // Commit on the edge entering WACK, echo the data as the ack beat
                state_d      = WACK;
                ram_we       = 1'b1;
                ram_widx     = op_idx;
                ram_wdata    = op_wdata;
                resp_last_d  = 1'b1;
                resp_rdata_d = op_wdata;
            end else begin
                state_d      = BURST;
                beat_d       = 5'd0;
                resp_last_d  = (LAST_BEAT == 5'd0);
                resp_rdata_d = ram[wrap_idx(op_idx, 5'd0)];
            end
        end
    end

    // Control and response registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            beat_q       <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Request payload capture; only meaningful while a transaction is active
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // Store write port; gated by reset so an uncommitted write is dropped
    always_ff @(posedge clk) begin
        if (ram_we && reset) begin
            ram[ram_widx] <= ram_wdata;
`ifdef MEM_TRACE_EN
            $display("[0x%08h]=0x%08h", 32'(ram_widx) << 2, ram_wdata);
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_last  = resp_last_q;
    assign resp_rdata = resp_rdata_q;

endmodule
